// File: rtl/mnacidpro_valve_sequencer_if.sv
// Control/status bundle between the run controller and the valve sequencer.
// The sequencer side is the slave; whoever issues start/abort is the master.
interface mnacidpro_valve_sequencer_if;
  logic        start;
  logic        abort;
  logic [10:0] valve_ctrl;
  logic [2:0]  pump;
  logic [10:0] valve_flush;
  logic [2:0]  pump_flush;
  logic [2:0]  step;
  logic        busy;
  logic        done;

  modport master (
    output start, abort,
    input  valve_ctrl, pump, valve_flush, pump_flush, step, busy, done
  );

  modport slave (
    input  start, abort,
    output valve_ctrl, pump, valve_flush, pump_flush, step, busy, done
  );
endinterface

// File: rtl/mnacidpro_valve_sequencer.sv
// Valve/pump sequencer for the mnacidpro purification chip: one fixed protocol per start
// (bead load, lysis, wash, elute, collect, flush). Ctrl lines: 1 = pressurised = closed.
module mnacidpro_valve_sequencer #(
  parameter int PUMP_DIV      = 4,
  parameter int STROKES_LOAD  = 8,
  parameter int STROKES_WASH  = 4,
  parameter int STROKES_ELUTE = 4,
  parameter int FLUSH_CYCLES  = 16,
  parameter int CNT_W         = 16
) (
  input logic                        clk,
  input logic                        rst,
  mnacidpro_valve_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BEAD    = 3'd1,
    LYSIS   = 3'd2,
    WASH    = 3'd3,
    ELUTE   = 3'd4,
    COLLECT = 3'd5,
    FLUSH   = 3'd6
  } state_t;

  state_t           st, st_n;
  logic [CNT_W-1:0] div_q, div_n;   // cycles within the current pump phase
  logic [CNT_W-1:0] cnt_q, cnt_n;   // strokes in pumped states, cycles in FLUSH
  logic [2:0]       ph_q, ph_n;
  logic             done_n;

  function automatic logic [CNT_W-1:0] last_stroke(state_t s);
    case (s)
      BEAD, LYSIS: last_stroke = CNT_W'(STROKES_LOAD - 1);
      WASH:        last_stroke = CNT_W'(STROKES_WASH - 1);
      default:     last_stroke = CNT_W'(STROKES_ELUTE - 1);
    endcase
  endfunction

  function automatic state_t next_of(state_t s);
    case (s)
      BEAD:    next_of = LYSIS;
      LYSIS:   next_of = WASH;
      WASH:    next_of = ELUTE;
      ELUTE:   next_of = COLLECT;
      COLLECT: next_of = FLUSH;
      default: next_of = IDLE;
    endcase
  endfunction

  function automatic logic [10:0] valve_of(state_t s);
    case (s)
      BEAD:    valve_of = 11'h51F;
      LYSIS:   valve_of = 11'h5AE;
      WASH:    valve_of = 11'h5AD;
      ELUTE:   valve_of = 11'h6E3;  // recirculation loop through dead_end/loop_exit
      COLLECT: valve_of = 11'h1EB;
      default: valve_of = 11'h7FF;
    endcase
  endfunction

  function automatic logic [2:0] pump_of(logic [2:0] p);
    case (p)
      3'd0:    pump_of = 3'b011;
      3'd1:    pump_of = 3'b001;
      3'd2:    pump_of = 3'b101;
      3'd3:    pump_of = 3'b100;
      3'd4:    pump_of = 3'b110;
      default: pump_of = 3'b010;
    endcase
  endfunction

  always_comb begin
    st_n   = st;
    div_n  = div_q;
    ph_n   = ph_q;
    cnt_n  = cnt_q;
    done_n = 1'b0;
    case (st)
      IDLE: begin
        if (bus.start) begin
          st_n  = BEAD;
          div_n = '0;
          ph_n  = '0;
          cnt_n = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          st_n   = IDLE;
          cnt_n  = '0;
          done_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        // A state ends on the last divider tick of the last phase of its last stroke.
        if (div_q == CNT_W'(PUMP_DIV - 1)) begin
          div_n = '0;
          if (ph_q == 3'd5) begin
            ph_n = '0;
            if (cnt_q == last_stroke(st)) begin
              st_n  = next_of(st);
              cnt_n = '0;
            end else begin
              cnt_n = cnt_q + 1'b1;
            end
          end else begin
            ph_n = ph_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
    endcase
    if (bus.abort && st != IDLE) begin
      st_n   = IDLE;
      div_n  = '0;
      ph_n   = '0;
      cnt_n  = '0;
      done_n = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as st.
  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= IDLE;
      div_q           <= '0;
      ph_q            <= '0;
      cnt_q           <= '0;
      bus.valve_ctrl  <= 11'h7FF;
      bus.pump        <= 3'b111;
      bus.valve_flush <= '0;
      bus.pump_flush  <= '0;
      bus.step        <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      st              <= st_n;
      div_q           <= div_n;
      ph_q            <= ph_n;
      cnt_q           <= cnt_n;
      bus.valve_ctrl  <= valve_of(st_n);
      bus.pump        <= (st_n == IDLE || st_n == FLUSH) ? 3'b111 : pump_of(ph_n);
      bus.valve_flush <= (st_n == FLUSH) ? 11'h7FF : 11'h000;
      bus.pump_flush  <= (st_n == FLUSH) ? 3'b111 : 3'b000;
      bus.step        <= st_n;
      bus.busy        <= (st_n != IDLE);
      bus.done        <= done_n;
    end
  end

endmodule
